// File: rtl/fft8_out_serializer.sv
// ---------------------------------------------------------------------------
// fft8_out_serializer
//
// Waits a fixed pipeline latency after the 8-point FFT inputs are applied,
// captures the eight parallel FFT output words into a local buffer and then
// streams them out one word per beat over a valid/ready interface, in natural
// or bit-reversed lane order.
//
// Parameters
//   WIDTH   : word width (packed complex, real in the upper half)
//   FFT_LAT : cycles from start to valid FFT outputs (0..15)
//   BITREV  : 0 = beat i from lane i, 1 = beat i from lane bitrev3(i)
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : one-cycle pulse in the cycle the FFT inputs are applied
//   fft_out  : eight FFT output lanes, lane k at [k*WIDTH +: WIDTH]
//   m_data   : current beat word
//   m_valid  : beat available
//   m_ready  : consumer accepts the beat
//   m_index  : source lane of the current beat
//   m_last   : high on beat 7
//   busy     : high while waiting for or streaming a frame
//   overrun  : sticky flag, set when a start pulse had to be dropped
// ---------------------------------------------------------------------------
module fft8_out_serializer #(
  parameter int WIDTH   = 32,
  parameter int FFT_LAT = 3,
  parameter int BITREV  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [8*WIDTH-1:0]   fft_out,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2:0]           m_index,
  output logic                 m_last,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Latency counter reload value; unused when the FFT output is immediate.
  localparam logic [3:0] LAT_M1   = (FFT_LAT == 0) ? 4'd0 : 4'(FFT_LAT - 1);
  localparam logic       LAT_ZERO = (FFT_LAT == 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_buf [8];
  logic [2:0]       r_idx;
  logic [3:0]       r_cnt;
  logic             r_overrun;

  logic             w_capture;
  logic             w_load_cnt;
  logic             w_dec_cnt;
  logic             w_advance;
  logic             w_drop;
  logic [2:0]       w_lane;

  // Beat number to source lane mapping.
  function automatic logic [2:0] lane_of(input logic [2:0] beat);
    if (BITREV != 0) begin
      return {beat[0], beat[1], beat[2]};
    end else begin
      return beat;
    end
  endfunction

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_load_cnt  = 1'b0;
    w_dec_cnt   = 1'b0;
    w_advance   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (LAT_ZERO) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_STREAM;
          end else begin
            w_load_cnt  = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A frame is already in flight, so any new start is lost.
        w_drop = start;
        if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_STREAM;
        end else begin
          w_dec_cnt   = 1'b1;
        end
      end
      ST_STREAM: begin
        // Only a start coinciding with the final handshake can be taken.
        w_drop = start && !(m_ready && (r_idx == 3'd7));
        if (m_ready) begin
          w_advance = 1'b1;
          if (r_idx == 3'd7) begin
            if (start) begin
              if (LAT_ZERO) begin
                w_capture   = 1'b1;
                w_state_nxt = ST_STREAM;
              end else begin
                w_load_cnt  = 1'b1;
                w_state_nxt = ST_WAIT;
              end
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_STREAM;
          end
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture buffer: written only when the FFT outputs become valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        r_buf[k] <= '0;
      end
    end else if (w_capture) begin
      for (int k = 0; k < 8; k++) begin
        r_buf[k] <= fft_out[k*WIDTH +: WIDTH];
      end
    end
  end

  // Beat counter: cleared on capture, advanced on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 3'd0;
    end else if (w_capture) begin
      r_idx <= 3'd0;
    end else if (w_advance) begin
      r_idx <= r_idx + 3'd1;
    end
  end

  // Latency counter for the WAIT phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_load_cnt) begin
      r_cnt <= LAT_M1;
    end else if (w_dec_cnt) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  // All outputs derive from registers only; m_ready never reaches them.
  assign w_lane  = lane_of(r_idx);
  assign m_data  = r_buf[w_lane];
  assign m_index = w_lane;
  assign m_valid = (r_state == ST_STREAM);
  assign m_last  = (r_state == ST_STREAM) && (r_idx == 3'd7);
  assign busy    = (r_state != ST_IDLE);
  assign overrun = r_overrun;

endmodule

// File: tb/tb_fft8_out_serializer.sv
// ---------------------------------------------------------------------------
// Bench for fft8_out_serializer. Three instances share all inputs:
//   0: FFT_LAT=3 natural order, 1: FFT_LAT=3 bit-reversed, 2: FFT_LAT=0.
// A frame-level model (expected word list + capture cycle) predicts every
// output each cycle; directed phases add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_fft8_out_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         m_ready = 1'b0;
  logic [255:0] fft_out = '0;

  logic [31:0]  md [3];
  logic         mv [3];
  logic [2:0]   mi [3];
  logic         ml [3];
  logic         mb [3];
  logic         mo [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fft8_out_serializer #(
      .WIDTH(32),
      .FFT_LAT((g == 2) ? 0 : 3),
      .BITREV((g == 1) ? 1 : 0)
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .fft_out(fft_out),
      .m_data(md[g]), .m_valid(mv[g]), .m_ready(m_ready),
      .m_index(mi[g]), .m_last(ml[g]), .busy(mb[g]), .overrun(mo[g])
    );
  end

  logic [31:0] lit_a [8] = '{32'h3c000000, 32'h40000000, 32'h42000000, 32'h44000000,
                             32'h44000000, 32'h42000000, 32'h40000000, 32'h3c000000};
  logic [31:0] iso   [8] = '{32'h3c010000, 32'h40450000, 32'h42890000, 32'h44cd0000,
                             32'h45110000, 32'h43550000, 32'h41990000, 32'h3ddd0000};
  logic [31:0] lit_b [8] = '{32'h10000000, 32'h10000004, 32'h10000002, 32'h10000006,
                             32'h10000001, 32'h10000005, 32'h10000003, 32'h10000007};

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 waiting for capture cycle, 2 streaming the word list
  int          mode   [3];
  longint      cap_at [3];
  logic [31:0] ew     [3][8];
  logic [2:0]  el     [3][8];
  int          pos    [3];
  bit          movr   [3];
  longint      cyc = 0;

  function automatic int lat_of(input int d);
    return (d == 2) ? 0 : 3;
  endfunction

  function automatic logic [2:0] order_of(input int d, input logic [2:0] k);
    if (d == 1) return {k[0], k[1], k[2]};
    return k;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mode[d] = 0; pos[d] = 0; movr[d] = 1'b0; cap_at[d] = 0;
    end
  endtask

  task automatic model_capture(input int d);
    for (int k = 0; k < 8; k++) begin
      el[d][k] = order_of(d, 3'(k));
      ew[d][k] = fft_out[32*int'(el[d][k]) +: 32];
    end
    pos[d]  = 0;
    mode[d] = 2;
  endtask

  task automatic model_begin(input int d);
    if (lat_of(d) == 0) begin
      model_capture(d);
    end else begin
      mode[d]   = 1;
      cap_at[d] = cyc + longint'(lat_of(d));
    end
  endtask

  task automatic model_edge(input int d);
    bit fin;
    case (mode[d])
      0: if (start) model_begin(d);
      1: begin
        if (start) movr[d] = 1'b1;
        if (cyc == cap_at[d]) model_capture(d);
      end
      2: begin
        fin = m_ready && (pos[d] == 7);
        if (start && !fin) movr[d] = 1'b1;
        if (m_ready) begin
          pos[d]++;
          if (pos[d] == 8) begin
            mode[d] = 0;
            pos[d]  = 0;
            if (start) model_begin(d);
          end
        end
      end
      default: mode[d] = 0;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic compare(input int d);
    bit v;
    v = (mode[d] == 2);
    chk($sformatf("valid[%0d]", d),   32'(mv[d]), 32'(v));
    chk($sformatf("busy[%0d]", d),    32'(mb[d]), 32'(mode[d] != 0));
    chk($sformatf("overrun[%0d]", d), 32'(mo[d]), 32'(movr[d]));
    chk($sformatf("last[%0d]", d),    32'(ml[d]), 32'(v && pos[d] == 7));
    chk($sformatf("index[%0d]", d),   32'(mi[d]), v ? 32'(el[d][pos[d]]) : 32'd0);
    if (v) chk($sformatf("data[%0d]", d), md[d], ew[d][pos[d]]);
  endtask

  // Model advance at each edge, full output comparison mid-cycle.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else for (int d = 0; d < 3; d++) model_edge(d);
      cyc++;
      @(negedge clk);
      if (!rst_n) model_reset();
      for (int d = 0; d < 3; d++) compare(d);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes_a();
    for (int k = 0; k < 8; k++) fft_out[k*32 +: 32] = lit_a[k];
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_data[%0d]", tag, d),    md[d], 32'd0);
      chk($sformatf("%s_valid[%0d]", tag, d),   32'(mv[d]), 32'd0);
      chk($sformatf("%s_index[%0d]", tag, d),   32'(mi[d]), 32'd0);
      chk($sformatf("%s_last[%0d]", tag, d),    32'(ml[d]), 32'd0);
      chk($sformatf("%s_busy[%0d]", tag, d),    32'(mb[d]), 32'd0);
      chk($sformatf("%s_overrun[%0d]", tag, d), 32'(mo[d]), 32'd0);
    end
  endtask

  initial begin
    // Power-on reset.
    step(); step();
    check_all_zero("por");
    rst_n = 1'b1;
    m_ready = 1'b1;

    // Natural order, capture isolation, FFT_LAT=0 latency.
    step(); start = 1'b1; set_lanes_a();
    for (int n = 1; n <= 13; n++) begin
      step(); start = 1'b0;
      if (n == 4) for (int k = 0; k < 8; k++) fft_out[k*32 +: 32] = iso[k];
      #1;
      if (n == 1) begin
        chk("lat0_valid_c1", 32'(mv[2]), 32'd1);
        chk("lat0_data_c1", md[2], 32'h3c000000);
      end
      if (n == 3) chk("nat_valid_c3", 32'(mv[0]), 32'd0);
      if (n >= 4 && n <= 11) begin
        chk($sformatf("nat_data_c%0d", n), md[0], lit_a[n-4]);
        chk($sformatf("nat_index_c%0d", n), 32'(mi[0]), 32'(n-4));
        chk($sformatf("nat_last_c%0d", n), 32'(ml[0]), 32'(n == 11));
      end
      if (n == 12) chk("nat_valid_c12", 32'(mv[0]), 32'd0);
    end

    // Bit-reversed order.
    step(); start = 1'b1;
    for (int k = 0; k < 8; k++) fft_out[k*32 +: 32] = 32'h10000000 + 32'(k);
    for (int n = 1; n <= 13; n++) begin
      step(); start = 1'b0; #1;
      if (n >= 4 && n <= 11) chk($sformatf("brev_data_c%0d", n), md[1], lit_b[n-4]);
    end

    // Start coincident with the final handshake.
    step(); start = 1'b1; set_lanes_a();
    for (int n = 1; n <= 26; n++) begin
      step(); start = (n == 11); #1;
      if (n == 11) chk("b2b_last_c11", 32'(ml[0]), 32'd1);
      if (n == 12) begin
        chk("b2b_overrun_c12", 32'(mo[0]), 32'd0);
        chk("b2b_valid_c12", 32'(mv[0]), 32'd0);
        chk("b2b_busy_c12", 32'(mb[0]), 32'd1);
      end
      if (n == 15) chk("b2b_valid_c15", 32'(mv[0]), 32'd1);
    end

    // Backpressure with ready pattern 1,0,0,1,...
    step(); start = 1'b1;
    for (int k = 0; k < 8; k++) fft_out[k*32 +: 32] = $urandom;
    for (int n = 1; n <= 45; n++) begin
      step(); start = 1'b0;
      m_ready = ((n % 4) == 0) || ((n % 4) == 3);
    end
    m_ready = 1'b1;
    repeat (12) step();

    // Start during WAIT.
    step(); start = 1'b1; set_lanes_a();
    for (int n = 1; n <= 14; n++) begin
      step(); start = (n == 2); #1;
      if (n == 3) chk("wait_overrun_c3", 32'(mo[0]), 32'd1);
      if (n == 12) chk("wait_noextra_c12", 32'(mv[0]), 32'd0);
    end

    // Reset in the middle of streaming.
    step(); start = 1'b1; set_lanes_a();
    for (int n = 1; n <= 6; n++) begin
      step(); start = 1'b0;
    end
    #1; rst_n = 1'b0; #1;
    check_all_zero("midrst");
    step(); step(); rst_n = 1'b1;
    repeat (15) step();

    // Start during beat 3.
    step(); start = 1'b1; set_lanes_a();
    for (int n = 1; n <= 14; n++) begin
      step(); start = (n == 7); #1;
      if (n == 8) chk("beat3_overrun_c8", 32'(mo[0]), 32'd1);
      if (n == 11) chk("beat3_data_c11", md[0], lit_a[7]);
      if (n == 12) chk("beat3_noextra_c12", 32'(mv[0]), 32'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step();
      start   = ($urandom_range(0, 11) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 8; k++) fft_out[k*32 +: 32] = $urandom;
    end
    start = 1'b0;
    m_ready = 1'b1;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
